wrr_sched: RTL and testbench

Parametrised weighted round-robin scheduler for NUM_Q ready-flagged queues. It sits between the per-queue ready flags and the shared dequeue/output stage, and issues a registered one-hot grant. A queue keeps the grant for up to its programmed number of accepted transfers, then the grant rotates to the next ready queue. It generalises the fixed three-queue scheduler with:
- arbitrary queue count;
- per-queue weights;
- a downstream acknowledge handshake;
- fair pointer rotation.

---
 rtl/wrr_sched.sv | 124 ++++++++++++
 tb/tb_wrr_sched.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/wrr_sched.sv
// wrr_sched: weighted round-robin scheduler issuing a registered one-hot grant over NUM_Q queues.
// Define WRR_SCHED_WEIGHT_EN for per-queue quanta; otherwise the grant rotates after every sel_ack.
module wrr_sched #(
    parameter int NUM_Q    = 4,
    parameter int WEIGHT_W = 4,
    parameter int IDX_W    = $clog2(NUM_Q)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_Q-1:0]          q_rdy,
    input  logic [NUM_Q*WEIGHT_W-1:0] weight,
    input  logic                      sel_ack,
    output logic [NUM_Q-1:0]          sel,
    output logic                      sel_vld,
    output logic [IDX_W-1:0]          sel_idx
);
    // state | meaning
    // IDLE  | no queue granted, sel all zeros
    // GRANT | queue cur holds the grant
    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cur_q, cur_d, ptr_q, ptr_d;
    logic [IDX_W-1:0] cur_inc, start, win, cand;
    logic [NUM_Q-1:0] sel_q, sel_d;
    logic             found, rearb, exhausted;

    assign cur_inc = (cur_q == IDX_W'(NUM_Q - 1)) ? '0 : cur_q + IDX_W'(1);
    // In GRANT the search starts after cur, so cur itself is considered last.
    assign start   = (state_q == GRANT) ? cur_inc : ptr_q;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = NUM_Q - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(start) + k) % NUM_Q);
            if (q_rdy[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

`ifdef WRR_SCHED_WEIGHT_EN
    logic [WEIGHT_W-1:0] credit_q, credit_d, w_win;
    logic                load;

    assign w_win     = weight[int'(win) * WEIGHT_W +: WEIGHT_W];
    assign exhausted = sel_ack && (credit_q == WEIGHT_W'(1));

    always_comb begin
        load     = (state_d == GRANT) && ((state_q == IDLE) || rearb);
        credit_d = credit_q;
        if (load)
            credit_d = (w_win == '0) ? WEIGHT_W'(1) : w_win;
        else if ((state_q == GRANT) && sel_ack && !rearb)
            credit_d = credit_q - WEIGHT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            credit_q <= '0;
        else
            credit_q <= credit_d;
    end
`else
    logic unused_weight;

    assign unused_weight = ^weight;
    assign exhausted     = sel_ack;
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        ptr_d   = ptr_q;
        rearb   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    cur_d   = win;
                end
            end
            GRANT: begin
                // A withdrawn queue takes precedence; any ack in that cycle is dropped.
                if (!q_rdy[cur_q] || exhausted)
                    rearb = 1'b1;
                if (rearb) begin
                    ptr_d = cur_inc;
                    if (found) begin
                        cur_d = win;
                    end else begin
                        state_d = IDLE;
                        cur_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_d = (state_d == GRANT) ? (NUM_Q'(1) << cur_d) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

    assign sel     = sel_q;
    assign sel_vld = (state_q == GRANT);
    assign sel_idx = cur_q;

endmodule

// File: tb/tb_wrr_sched.sv
// tb_wrr_sched: directed checks of wrr_sched with a 4-queue and a 3-queue instance.
// Expectations follow WRR_SCHED_WEIGHT_EN when defined, plain round-robin otherwise.
module tb_wrr_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  q_rdy4;
    logic [15:0] weight4;
    logic        ack4;
    logic [3:0]  sel4;
    logic        sel_vld4;
    logic [1:0]  sel_idx4;
    logic [2:0]  q_rdy3;
    logic [11:0] weight3;
    logic        ack3;
    logic [2:0]  sel3;
    logic        sel_vld3;
    logic [1:0]  sel_idx3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wrr_sched #(.NUM_Q(4), .WEIGHT_W(4)) u4 (
        .clk(clk), .rst(rst), .q_rdy(q_rdy4), .weight(weight4), .sel_ack(ack4),
        .sel(sel4), .sel_vld(sel_vld4), .sel_idx(sel_idx4)
    );

    wrr_sched #(.NUM_Q(3), .WEIGHT_W(4)) u3 (
        .clk(clk), .rst(rst), .q_rdy(q_rdy3), .weight(weight3), .sel_ack(ack3),
        .sel(sel3), .sel_vld(sel_vld3), .sel_idx(sel_idx3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input int idx);
        chk({tag, ".sel"}, 32'(sel4), 32'(1) << idx);
        chk({tag, ".vld"}, 32'(sel_vld4), 32'd1);
        chk({tag, ".idx"}, 32'(sel_idx4), 32'(idx));
    endtask

    task automatic chk4_idle(input string tag);
        chk({tag, ".sel"}, 32'(sel4), 32'd0);
        chk({tag, ".vld"}, 32'(sel_vld4), 32'd0);
        chk({tag, ".idx"}, 32'(sel_idx4), 32'd0);
    endtask

    task automatic chk3(input string tag, input int idx);
        chk({tag, ".sel"}, 32'(sel3), 32'(1) << idx);
        chk({tag, ".vld"}, 32'(sel_vld3), 32'd1);
        chk({tag, ".idx"}, 32'(sel_idx3), 32'(idx));
    endtask

`ifdef WRR_SCHED_WEIGHT_EN
    int exp_rot[8]   = '{1, 1, 1, 2, 2, 3, 0, 1};
    int exp_drain[4] = '{1, 2, 2, 3};
    int exp_wrap[4]  = '{2, 0, 1, 2};
`else
    int exp_rot[8]   = '{1, 2, 3, 0, 1, 2, 3, 0};
    int exp_drain[4] = '{1, 2, 3, 0};
    int exp_wrap[4]  = '{0, 1, 2, 0};
`endif

    initial begin
        rst     = 1'b1;
        q_rdy4  = 4'b1111;
`ifdef WRR_SCHED_WEIGHT_EN
        weight4 = 16'h1231;
`else
        weight4 = 16'h4444;
`endif
        ack4    = 1'b0;
        q_rdy3  = 3'b000;
        weight3 = 12'h211;
        ack3    = 1'b0;

        repeat (2) step();
        chk4_idle("reset");
        chk("reset3.vld", 32'(sel_vld3), 32'd0);

        rst = 1'b0;
        step();
        chk4("first_grant", 0);
        step();
        chk4("hold_no_ack", 0);

        ack4 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk4($sformatf("rotate%0d", i), exp_rot[i]);
        end

        step();
        chk4("drain0", exp_drain[0]);
        q_rdy4 = 4'b1101;
        for (int i = 1; i < 4; i++) begin
            step();
            chk4($sformatf("drain%0d", i), exp_drain[i]);
        end

        q_rdy4 = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step();
            chk4($sformatf("lone%0d", i), 2);
        end

        q_rdy4 = 4'b0000;
        step();
        chk4_idle("empty");
        step();
        chk4_idle("ack_while_idle");
        q_rdy4 = 4'b1001;
        ack4   = 1'b0;
        step();
        chk4("ptr_after_idle", 3);

        rst = 1'b1;
        #2;
        chk4_idle("async_reset");
        step();
        chk4_idle("reset_held");
        rst = 1'b0;
        step();
        chk4("ptr_reset", 0);

        q_rdy4 = 4'b0000;
        q_rdy3 = 3'b100;
        step();
        chk3("q3_first", 2);
        q_rdy3 = 3'b111;
        ack3   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk3($sformatf("wrap%0d", i), exp_wrap[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
